grex_meas_sched: RTL and testbench
==================================

# grex_meas_sched

Measurement scheduler for the GREX temperature-sensor front-end controller. Issues conversion start pulses on single requests or on a programmable period, and waits for each conversion-done with a timeout. Averages 2^AVG_LOG2 raw counts per measurement and presents the result on a valid/ready port for the register/readout logic.

## Interface
- CNT_W, 8: width of raw conversion count and result
- AVG_LOG2, 2: log2 of samples averaged per measurement (0..4)
- TIMEOUT, 255: max cycles waited for conv_done per sample (≥1)
- PER_W, 16: width of period input/timer
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_single  in  1  one-cycle pulse: request one measurement
- cont_en  in  1  continuous mode enable
- period  in  PER_W  cycles between periodic requests; 0 = no periodic requests
- conv_start  out  1  one-cycle start pulse to front-end controller
- conv_done  in  1  one-cycle pulse, conv_count valid
- conv_count  in  CNT_W  raw integration count
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  CNT_W  averaged count
- res_timeout  out  1  result aborted by timeout
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky: periodic tick dropped
- alarm_thr  in  CNT_W  alarm threshold
- alarm_clr  in  1  clears alarm
- alarm  out  1  sticky alarm flag

## Operation
- Reset: state IDLE; all outputs 0; acc, idx, timers, pending flags cleared. Any cycle with reset high overrides everything, including mid-WAIT/OUT.
- Pending flag set by req_single pulse or periodic tick; set while busy holds one request only. Tick while flag already set → overrun=1 (sticky until reset). Single+tick in same cycle → one request, no overrun.
- Period timer: runs only when cont_en=1 and period≠0; counts 0..period-1, tick when count==period-1, then wraps to 0. cont_en low → timer held at 0.
- States:
  - IDLE: pending → START; clear pending, acc=0, idx=0.
  - START: conv_start=1 this cycle; wait counter=0 → WAIT.
  - WAIT: conv_done → acc+=conv_count; if idx==2^AVG_LOG2-1 → OUT, else idx+=1 → START. Else wait counter==TIMEOUT-1 → OUT with timeout flag set.
  - OUT: res_valid=1; res_data and res_timeout held stable; res_ready=1 → IDLE, res_valid drops next cycle.
- acc width CNT_W+AVG_LOG2, no overflow possible; res_data = acc >> AVG_LOG2 (truncate).
- Timeout: res_data=0, res_timeout=1, remaining samples abandoned.
- conv_done outside WAIT ignored. conv_done in the same cycle as timeout expiry: done wins.
- res_timeout cleared on next START.

## Timing
- conv_start registered, high exactly one cycle, one cycle after IDLE→START decision.
- Pending request in IDLE at cycle n → conv_start high at n+1.
- conv_done at cycle n → next conv_start at n+1 (START entered n+1), or res_valid at n+1 for last sample.
- Timeout: res_valid rises TIMEOUT+1 cycles after conv_start if no done.
- Minimum measurement: 2·2^AVG_LOG2 + 1 cycles plus front-end latency.
- res_valid/ready: transfer on the cycle both high; no combinational path from res_ready to any output.

## Configuration
- GREX_ALARM_EN defined: on OUT entry with res_timeout=0 and averaged result > alarm_thr, alarm=1 next cycle; stays 1 until alarm_clr or reset; alarm_clr and set in same cycle → set wins.
- Undefined: alarm tied 0; alarm_thr, alarm_clr present but ignored.

## Structure
- Package grex_sched_pkg: state enum (S_IDLE, S_START, S_WAIT, S_OUT), default parameter constants.
- Sub-module grex_period_timer: period counter, cont_en gating, tick output.

## Test plan
- Single request, AVG_LOG2=2, counts 60,61,62,63 → 4 conv_start pulses, res_data=61, res_timeout=0, busy low after handshake.
- TIMEOUT=20, no conv_done → res_valid 21 cycles after conv_start, res_data=0, res_timeout=1.
- res_ready held low 10 cycles in OUT → res_data stable throughout; tick during OUT sets pending, second measurement starts 1 cycle after return to IDLE.
- cont_en=1, period=100, front-end done within 5 cycles → conv_start bursts every 100 cycles, overrun=0; period=8 with slow done → overrun=1.
- reset asserted mid-WAIT with late conv_done → next cycle all outputs 0, state IDLE, done ignored, no res_valid.
- GREX_ALARM_EN, alarm_thr=50, result 61 → alarm=1; alarm_clr → 0; without macro alarm stays 0.

Source files
------------

// File: rtl/grex_sched_pkg.sv
// grex_sched_pkg
// Shared definitions for the GREX measurement scheduler:
//   - sched_state_e : scheduler FSM state encoding
//   - DEF_*         : default parameter values used by the interface and the top
//   - cnt_bits()    : width needed to hold a counter value 0..max_val
package grex_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } sched_state_e;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_AVG_LOG2 = 2;
  localparam int DEF_TIMEOUT  = 255;
  localparam int DEF_PER_W    = 16;

  // Width of a counter that must reach max_val (at least one bit).
  function automatic int cnt_bits(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/grex_meas_sched_if.sv
// grex_meas_sched_if
// Bundles the two handshakes of the measurement scheduler:
//   conversion side : conv_start (to front-end), conv_done / conv_count (from front-end)
//   result side     : res_valid / res_data / res_timeout (to consumer), res_ready (from consumer)
// Modports:
//   master : the scheduler (drives conv_start and the result bus)
//   slave  : front-end controller plus result consumer
interface grex_meas_sched_if #(
  parameter int CNT_W = grex_sched_pkg::DEF_CNT_W
);

  logic             conv_start;
  logic             conv_done;
  logic [CNT_W-1:0] conv_count;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_data;
  logic             res_timeout;

  modport master (
    output conv_start,
    input  conv_done,
    input  conv_count,
    output res_valid,
    input  res_ready,
    output res_data,
    output res_timeout
  );

  modport slave (
    input  conv_start,
    output conv_done,
    output conv_count,
    input  res_valid,
    output res_ready,
    input  res_data,
    input  res_timeout
  );

endinterface

// File: rtl/grex_period_timer.sv
// grex_period_timer
// Free-running period counter for continuous measurement mode.
// Counts 0..period-1 while cont_en=1 and period!=0 and flags tick on the
// last count, then wraps. Disabled (cont_en=0 or period=0) holds the count at 0.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   cont_en    : continuous mode enable
//   period     : cycles between ticks (0 = never tick)
//   tick       : high for one cycle every period cycles
module grex_period_timer #(
  parameter int PER_W = grex_sched_pkg::DEF_PER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cont_en,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] count_r;
  logic             run_s;
  logic             wrap_s;

  // Run/wrap decode. ">=" also recovers at once if period is lowered below
  // the current count instead of running all the way round the counter.
  always_comb begin
    run_s = cont_en && (period != {PER_W{1'b0}});
    if (run_s) begin
      wrap_s = (count_r >= (period - PER_W'(1'b1)));
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Period counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {PER_W{1'b0}};
    end else if (!run_s) begin
      count_r <= {PER_W{1'b0}};
    end else if (wrap_s) begin
      count_r <= {PER_W{1'b0}};
    end else begin
      count_r <= count_r + PER_W'(1'b1);
    end
  end

  assign tick = wrap_s;

endmodule

// File: rtl/grex_meas_sched.sv
// grex_meas_sched
// Measurement scheduler for the GREX temperature-sensor front-end.
// Turns single requests (req_single) or periodic ticks (cont_en/period) into
// a burst of 2^AVG_LOG2 conversions, waits up to TIMEOUT cycles for each
// conv_done, averages the counts and offers the result on a valid/ready port.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   bus (master)  : conv_start/conv_done/conv_count and res_valid/res_ready/
//                   res_data/res_timeout
//   req_single    : one-cycle single measurement request
//   cont_en       : continuous mode enable
//   period        : continuous mode period in cycles (0 = off)
//   busy          : scheduler not idle
//   overrun       : sticky, a periodic tick was dropped
//   alarm_thr     : alarm threshold on the averaged result
//   alarm_clr     : clears the alarm flag
//   alarm         : sticky alarm flag
// Build option: define GREX_ALARM_EN to enable the threshold alarm; without it
// alarm is tied to 0 and alarm_thr/alarm_clr are ignored.
module grex_meas_sched
  import grex_sched_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int PER_W    = DEF_PER_W
) (
  input  logic             clk,
  input  logic             reset,
  grex_meas_sched_if.master bus,
  input  logic             req_single,
  input  logic             cont_en,
  input  logic [PER_W-1:0] period,
  output logic             busy,
  output logic             overrun,
  input  logic [CNT_W-1:0] alarm_thr,
  input  logic             alarm_clr,
  output logic             alarm
);

  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int IDX_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int WAIT_W = cnt_bits(TIMEOUT);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  sched_state_e      state_r;
  sched_state_e      state_s;

  logic              tick_s;
  logic              req_any_s;
  logic              consume_s;
  logic              pending_r;
  logic              overrun_r;

  logic [ACC_W-1:0]  acc_r;
  logic [IDX_W-1:0]  idx_r;
  logic [WAIT_W-1:0] wait_r;
  logic [ACC_W-1:0]  sum_s;
  logic [CNT_W-1:0]  avg_s;
  logic              last_done_s;
  logic              expire_s;

  logic              conv_start_s;
  logic              res_valid_s;
  logic              busy_s;
  logic [CNT_W-1:0]  res_data_s;
  logic              res_timeout_s;

  logic              conv_start_r;
  logic              res_valid_r;
  logic [CNT_W-1:0]  res_data_r;
  logic              res_timeout_r;
  logic              busy_r;

  grex_period_timer #(
    .PER_W (PER_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .cont_en (cont_en),
    .period  (period),
    .tick    (tick_s)
  );

  // Request sources, pending consumption and WAIT-state events.
  always_comb begin
    req_any_s   = req_single | tick_s;
    consume_s   = (state_r == S_IDLE) && pending_r;
    sum_s       = acc_r + ACC_W'(bus.conv_count);
    avg_s       = CNT_W'(sum_s >> AVG_LOG2);
    last_done_s = (state_r == S_WAIT) && bus.conv_done && (idx_r == IDX_LAST);
    // conv_done on the expiry cycle wins, hence the !conv_done term.
    expire_s    = (state_r == S_WAIT) && !bus.conv_done && (wait_r == WAIT_LAST);
  end

  // Pending request flag and sticky overrun. A new request in the cycle the
  // old one is consumed is kept as the next pending request, not an overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (req_any_s) begin
        pending_r <= 1'b1;
      end else if (consume_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
      if (tick_s && pending_r && !consume_s) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pending_r) begin
          state_s = S_START;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (bus.conv_done) begin
          if (idx_r == IDX_LAST) begin
            state_s = S_OUT;
          end else begin
            state_s = S_START;
          end
        end else if (wait_r == WAIT_LAST) begin
          state_s = S_OUT;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_OUT: begin
        if (bus.res_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_OUT;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM output logic: next values of the registered outputs, decoded from the
  // next state so every output changes together with the state register.
  always_comb begin
    conv_start_s  = (state_s == S_START);
    res_valid_s   = (state_s == S_OUT);
    busy_s        = (state_s != S_IDLE);
    res_data_s    = res_data_r;
    res_timeout_s = res_timeout_r;
    if (last_done_s) begin
      res_data_s    = avg_s;
      res_timeout_s = 1'b0;
    end else if (expire_s) begin
      res_data_s    = {CNT_W{1'b0}};
      res_timeout_s = 1'b1;
    end else if (state_s == S_START) begin
      res_data_s    = res_data_r;
      res_timeout_s = 1'b0;
    end else begin
      res_data_s    = res_data_r;
      res_timeout_s = res_timeout_r;
    end
  end

  // Accumulator, sample index and per-sample wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r  <= {ACC_W{1'b0}};
      idx_r  <= {IDX_W{1'b0}};
      wait_r <= {WAIT_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          acc_r  <= {ACC_W{1'b0}};
          idx_r  <= {IDX_W{1'b0}};
          wait_r <= {WAIT_W{1'b0}};
        end
        S_START: begin
          wait_r <= {WAIT_W{1'b0}};
        end
        S_WAIT: begin
          if (bus.conv_done) begin
            acc_r <= sum_s;
            idx_r <= idx_r + IDX_W'(1'b1);
          end else begin
            wait_r <= wait_r + WAIT_W'(1'b1);
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_start_r  <= 1'b0;
      res_valid_r   <= 1'b0;
      res_data_r    <= {CNT_W{1'b0}};
      res_timeout_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      conv_start_r  <= conv_start_s;
      res_valid_r   <= res_valid_s;
      res_data_r    <= res_data_s;
      res_timeout_r <= res_timeout_s;
      busy_r        <= busy_s;
    end
  end

  assign bus.conv_start  = conv_start_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_data    = res_data_r;
  assign bus.res_timeout = res_timeout_r;
  assign busy            = busy_r;
  assign overrun         = overrun_r;

`ifdef GREX_ALARM_EN
  logic out_entry_r;
  logic alarm_set_s;
  logic alarm_r;

  // Marks the first cycle spent in OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_entry_r <= 1'b0;
    end else begin
      out_entry_r <= (state_s == S_OUT) && (state_r != S_OUT);
    end
  end

  // Alarm condition, evaluated once per result on OUT entry.
  always_comb begin
    alarm_set_s = out_entry_r && !res_timeout_r && (res_data_r > alarm_thr);
  end

  // Sticky alarm flag; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_r <= 1'b0;
    end else if (alarm_set_s) begin
      alarm_r <= 1'b1;
    end else if (alarm_clr) begin
      alarm_r <= 1'b0;
    end else begin
      alarm_r <= alarm_r;
    end
  end

  assign alarm = alarm_r;
`else
  logic unused_alarm_s;
  assign unused_alarm_s = ^{alarm_thr, alarm_clr};
  assign alarm          = 1'b0;
`endif

endmodule

// File: tb/tb_grex_meas_sched.sv
// tb_grex_meas_sched
// Self-checking bench for grex_meas_sched (AVG_LOG2=2, TIMEOUT=20).
// Expected results are computed from the measurement rules: average of the
// driven counts (sum >> AVG_LOG2), or 0 with timeout when a sample's done
// delay exceeds TIMEOUT cycles. Honours GREX_ALARM_EN for the alarm checks.
module tb_grex_meas_sched;

  localparam int CNT_W    = 8;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 20;
  localparam int PER_W    = 16;
  localparam int NS       = 1 << AVG_LOG2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req_single = 1'b0;
  logic             cont_en = 1'b0;
  logic [PER_W-1:0] period = '0;
  logic [CNT_W-1:0] alarm_thr = 8'd50;
  logic             alarm_clr = 1'b0;
  logic             busy;
  logic             overrun;
  logic             alarm;

  grex_meas_sched_if #(.CNT_W(CNT_W)) bus ();

  grex_meas_sched #(
    .CNT_W    (CNT_W),
    .AVG_LOG2 (AVG_LOG2),
    .TIMEOUT  (TIMEOUT),
    .PER_W    (PER_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .req_single (req_single),
    .cont_en    (cont_en),
    .period     (period),
    .busy       (busy),
    .overrun    (overrun),
    .alarm_thr  (alarm_thr),
    .alarm_clr  (alarm_clr),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  int cnt_a[NS];
  int dly_a[NS];

  // front-end responder state for the continuous-mode runs
  int fe_cd  = 0;
  int fe_sum = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one measurement from the first conv_start point through the
  // handshake, with counts/delays from cnt_a/dly_a.
  task automatic meas_body(input int hold, input int req_h, input bit chk_alarm);
    int  sum;
    bit  tout;
    int  exp_data;
    int  exp_alarm;
    sum  = 0;
    tout = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!tout) begin
        check("start_pulse", bus.conv_start, 1);
        check("busy_meas", busy, 1);
        if (i == 0) check("tout_cleared_on_start", bus.res_timeout, 0);
        step();
        check("start_one_cycle", bus.conv_start, 0);
        if (dly_a[i] > TIMEOUT) begin
          for (int t = 2; t <= TIMEOUT; t++) step();
          check("valid_before_timeout", bus.res_valid, 0);
          step();
          tout = 1'b1;
        end else begin
          for (int t = 2; t <= dly_a[i]; t++) step();
          bus.conv_count = CNT_W'(cnt_a[i]);
          bus.conv_done  = 1'b1;
          step();
          bus.conv_done  = 1'b0;
          sum += cnt_a[i];
        end
      end
    end
    exp_data = tout ? 0 : (sum >> AVG_LOG2);
`ifdef GREX_ALARM_EN
    exp_alarm = (!tout && (exp_data > int'(alarm_thr))) ? 1 : 0;
`else
    exp_alarm = 0;
`endif
    check("res_valid", bus.res_valid, 1);
    check("res_data", bus.res_data, exp_data);
    check("res_timeout", bus.res_timeout, tout);
    for (int h = 0; h < hold; h++) begin
      if (h == req_h) req_single = 1'b1;
      step();
      req_single = 1'b0;
      check("hold_valid", bus.res_valid, 1);
      check("hold_data", bus.res_data, exp_data);
      check("hold_timeout", bus.res_timeout, tout);
      if (chk_alarm) check("alarm_level", alarm, exp_alarm);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("valid_drop_after_xfer", bus.res_valid, 0);
  endtask

  // Continuous mode with an automatic front-end answering after dmin..dmax
  // cycles and a consumer that is always ready.
  task automatic run_auto(input int ncyc, input int dmin, input int dmax,
                          input bit chk_gap, input int exp_starts);
    int starts[$];
    bus.res_ready = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      step();
      bus.conv_done = 1'b0;
      if (bus.res_valid) begin
        check("auto_data", bus.res_data, fe_sum >> AVG_LOG2);
        check("auto_timeout", bus.res_timeout, 0);
        fe_sum = 0;
      end
      if (bus.conv_start) begin
        starts.push_back(c);
        fe_cd = $urandom_range(dmin, dmax);
      end else if (fe_cd > 0) begin
        fe_cd--;
        if (fe_cd == 0) begin
          bus.conv_count = CNT_W'($urandom);
          bus.conv_done  = 1'b1;
          fe_sum += int'(bus.conv_count);
        end
      end
    end
    if (chk_gap) begin
      check("period_start_count", starts.size(), exp_starts);
      for (int k = NS; k < starts.size(); k += NS)
        check("period_gap", starts[k] - starts[k-NS], int'(period));
    end
  endtask

  initial begin
    bit seen_valid;
    bit seen_start;
    bus.conv_done  = 1'b0;
    bus.conv_count = '0;
    bus.res_ready  = 1'b0;

    // reset state
    step();
    step();
    check("rst_conv_start", bus.conv_start, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_alarm", alarm, 0);
    reset = 1'b0;
    step();

    // 60,61,62,63 with consumer stalled 10 cycles; a request during OUT
    cnt_a = '{60, 61, 62, 63};
    dly_a = '{1, 2, 3, 4};
    req_single = 1'b1;
    step();
    req_single = 1'b0;
    check("req_latency", bus.conv_start, 0);
    step();
    meas_body(10, 3, 1'b1);
    alarm_clr = 1'b1;
    step();
    alarm_clr = 1'b0;
    check("alarm_cleared", alarm, 0);
    check("pending_from_out", bus.conv_start, 1);
    cnt_a = '{0, 0, 0, 3};
    dly_a = '{1, 1, 1, 1};
    meas_body(0, -1, 1'b0);
    check("idle_after_xfer", busy, 0);

    // timeout on the second sample, then done exactly at the timeout limit
    cnt_a = '{100, 100, 100, 100};
    dly_a = '{3, TIMEOUT + 4, 1, 1};
    req_single = 1'b1;
    step();
    req_single = 1'b0;
    step();
    meas_body(2, -1, 1'b0);
    cnt_a = '{255, 255, 255, 255};
    dly_a = '{TIMEOUT, TIMEOUT, 1, 1};
    req_single = 1'b1;
    step();
    req_single = 1'b0;
    step();
    meas_body(1, -1, 1'b0);

    // randomized single measurements
    for (int m = 0; m < 8; m++) begin
      for (int i = 0; i < NS; i++) begin
        cnt_a[i] = $urandom_range(0, 255);
        dly_a[i] = ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 + $urandom_range(0, 5)
                                               : $urandom_range(1, TIMEOUT);
      end
      req_single = 1'b1;
      step();
      req_single = 1'b0;
      step();
      meas_body($urandom_range(0, 3), -1, 1'b0);
      check("rand_idle", busy, 0);
    end

    // continuous mode: fast front-end, then slow front-end with period 8
    period  = 16'd100;
    cont_en = 1'b1;
    run_auto(450, 1, 5, 1'b1, 16);
    check("overrun_fast", overrun, 0);
    cont_en = 1'b0;
    run_auto(80, 1, 5, 1'b0, 0);
    period  = 16'd8;
    cont_en = 1'b1;
    run_auto(300, 10, TIMEOUT, 1'b0, 0);
    check("overrun_slow", overrun, 1);
    cont_en = 1'b0;
    run_auto(300, 10, TIMEOUT, 1'b0, 0);
    bus.res_ready = 1'b0;
    check("drained_idle", busy, 0);

    // reset in the middle of WAIT, then a late conv_done
    req_single = 1'b1;
    step();
    req_single = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    check("mid_rst_conv_start", bus.conv_start, 0);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_res_data", bus.res_data, 0);
    check("mid_rst_res_timeout", bus.res_timeout, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_alarm", alarm, 0);
    reset = 1'b0;
    bus.conv_count = 8'd200;
    bus.conv_done  = 1'b1;
    step();
    bus.conv_done  = 1'b0;
    seen_valid = 1'b0;
    seen_start = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.res_valid) seen_valid = 1'b1;
      if (bus.conv_start) seen_start = 1'b1;
    end
    check("late_done_no_valid", seen_valid, 0);
    check("late_done_no_start", seen_start, 0);
    check("late_done_idle", busy, 0);

    // normal measurement after the reset
    cnt_a = '{10, 20, 30, 41};
    for (int i = 0; i < NS; i++) dly_a[i] = $urandom_range(1, 6);
    req_single = 1'b1;
    step();
    req_single = 1'b0;
    step();
    meas_body(0, -1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
